// File: rtl/clk_en_gen_multi.sv
// clk_en_gen_multi: multi-channel programmable tick/square-wave divider with free-running counter
module clk_en_gen_multi #(
   parameter int CH          = 4,
   parameter int DIVW        = 16,
   parameter int CNTW        = 32,
   parameter int DEFAULT_DIV = 1
) (
   input  logic            clk,
   input  logic            rst,
   output logic [CNTW-1:0] cnt,
   input  logic [CH-1:0]   en,
   input  logic            cfg_we,
   input  logic [3:0]      cfg_ch,
   input  logic [DIVW-1:0] cfg_div,
   output logic            cfg_ack,
   output logic [CH-1:0]   tick,
   output logic [CH-1:0]   sq
);
   logic acc;
   assign acc = cfg_we && (32'(cfg_ch) < CH);
   always_ff @(posedge clk)
      if (rst) begin
         cnt     <= '0;
         cfg_ack <= 1'b0;
      end else begin
         cnt     <= cnt + CNTW'(1);
         cfg_ack <= acc;
      end
   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [DIVW-1:0] c, act, shd;
      logic [DIVW:0]   h;
      logic            pend, t_r, s_r, wr, term, wrap;
      assign wr   = acc && (cfg_ch == 4'(i));
      assign term = c == act;
      // a period boundary is either the terminal count or leaving RUN; both are safe points to swap divisors
      assign wrap = !en[i] || term;
      assign h    = ({1'b0, act} + (DIVW+1)'(2)) >> 1;
      always_ff @(posedge clk)
         if (rst) begin
            c    <= '0;
            act  <= DIVW'(DEFAULT_DIV);
            shd  <= DIVW'(DEFAULT_DIV);
            pend <= 1'b0;
            t_r  <= 1'b0;
            s_r  <= 1'b0;
         end else begin
            t_r  <= en[i] && term;
            s_r  <= en[i] && ({1'b0, c} < h);
            c    <= wrap ? '0 : c + DIVW'(1);
            shd  <= wr ? cfg_div : shd;
            act  <= (wr && wrap) ? cfg_div : (pend && wrap) ? shd : act;
            pend <= !wrap && (wr || pend);
         end
      assign tick[i] = t_r;
      assign sq[i]   = s_r;
   end
endmodule

// File: tb/tb_clk_en_gen_multi.sv
// tb_clk_en_gen_multi: directed table-driven check of clk_en_gen_multi (CH=4, DIVW=16, CNTW=4)
module tb_clk_en_gen_multi;
   localparam int CH = 4, DIVW = 16, CNTW = 4;
   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [CNTW-1:0] cnt;
   logic [CH-1:0]   en = '0;
   logic            cfg_we = 1'b0;
   logic [3:0]      cfg_ch = '0;
   logic [DIVW-1:0] cfg_div = '0;
   logic            cfg_ack;
   logic [CH-1:0]   tick, sq;

   clk_en_gen_multi #(.CH(CH), .DIVW(DIVW), .CNTW(CNTW), .DEFAULT_DIV(1)) dut (
      .clk(clk), .rst(rst), .cnt(cnt), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_ack(cfg_ack), .tick(tick), .sq(sq));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  en;
      logic        we;
      logic [3:0]  ch;
      logic [15:0] dv;
      logic [3:0]  t, s;
      logic        ack;
   } vec_t;
   vec_t tbl[$];

   int pass_n = 0, total_n = 0, step_n = 0;
   logic [CNTW-1:0] exp_cnt = '0;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      total_n++;
      if (got === exp) pass_n++;
      else $display("FAIL %s step %0d: got %0h expected %0h", name, step_n, got, exp);
   endtask

   task automatic step(input logic r, input logic [3:0] e, input logic w, input logic [3:0] c,
                       input logic [15:0] d, input logic [3:0] et, input logic [3:0] es, input logic ea);
      @(negedge clk);
      rst = r; en = e; cfg_we = w; cfg_ch = c; cfg_div = d;
      @(posedge clk);
      #1;
      step_n++;
      exp_cnt = r ? '0 : exp_cnt + CNTW'(1);
      chk("tick", 16'(tick), 16'(et));
      chk("sq", 16'(sq), 16'(es));
      chk("cfg_ack", 16'(cfg_ack), 16'(ea));
      chk("cnt", 16'(cnt), 16'(exp_cnt));
   endtask

   task automatic add(input logic [3:0] e, input logic w, input logic [3:0] c, input logic [15:0] d,
                      input logic [3:0] t, input logic [3:0] s, input logic a);
      vec_t v;
      v.en = e; v.we = w; v.ch = c; v.dv = d; v.t = t; v.s = s; v.ack = a;
      tbl.push_back(v);
   endtask

   initial begin
      // idle after reset, then ch0 at default D=1
      add(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(4'b0001, 0, 0, 0, 4'b0000, 4'b0001, 0);
      add(4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 0);
      add(4'b0001, 0, 0, 0, 4'b0000, 4'b0001, 0);
      add(4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 0);
      // ch1 D=4 loaded while idle, rewritten to 2 at c=1
      add(4'b0000, 1, 1, 4, 4'b0000, 4'b0000, 1);
      add(4'b0010, 0, 0, 0, 4'b0000, 4'b0010, 0);
      add(4'b0010, 1, 1, 2, 4'b0000, 4'b0010, 1);
      add(4'b0010, 0, 0, 0, 4'b0000, 4'b0010, 0);
      add(4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(4'b0010, 0, 0, 0, 4'b0010, 4'b0000, 0);
      add(4'b0010, 0, 0, 0, 4'b0000, 4'b0010, 0);
      add(4'b0010, 0, 0, 0, 4'b0000, 4'b0010, 0);
      add(4'b0010, 0, 0, 0, 4'b0010, 4'b0000, 0);
      add(4'b0010, 0, 0, 0, 4'b0000, 4'b0010, 0);
      add(4'b0010, 0, 0, 0, 4'b0000, 4'b0010, 0);
      // write on terminal count takes effect for the very next period
      add(4'b0010, 1, 1, 1, 4'b0010, 4'b0000, 1);
      add(4'b0010, 0, 0, 0, 4'b0000, 4'b0010, 0);
      add(4'b0010, 0, 0, 0, 4'b0010, 4'b0000, 0);
      // out-of-range channel ignored
      add(4'b0010, 1, 7, 9, 4'b0000, 4'b0010, 0);
      add(4'b0010, 0, 0, 0, 4'b0010, 4'b0000, 0);
      // ch2 D=3, dropped at c=2 for 3 cycles, then full restart
      add(4'b0000, 1, 2, 3, 4'b0000, 4'b0000, 1);
      add(4'b0100, 0, 0, 0, 4'b0000, 4'b0100, 0);
      add(4'b0100, 0, 0, 0, 4'b0000, 4'b0100, 0);
      add(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(4'b0100, 0, 0, 0, 4'b0000, 4'b0100, 0);
      add(4'b0100, 0, 0, 0, 4'b0000, 4'b0100, 0);
      add(4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(4'b0100, 0, 0, 0, 4'b0100, 4'b0000, 0);
      add(4'b0100, 0, 0, 0, 4'b0000, 4'b0100, 0);
      // pending D=0 committed when en falls, then tick every cycle with sq stuck high
      add(4'b0100, 1, 2, 0, 4'b0000, 4'b0100, 1);
      add(4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(4'b0100, 0, 0, 0, 4'b0100, 4'b0100, 0);
      add(4'b0100, 0, 0, 0, 4'b0100, 4'b0100, 0);

      step(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
      step(1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);
      foreach (tbl[k]) step(0, tbl[k].en, tbl[k].we, tbl[k].ch, tbl[k].dv, tbl[k].t, tbl[k].s, tbl[k].ack);

      // reset with a pending write on ch3 must restore D=1 on all channels
      step(0, 4'b1100, 1, 3, 6, 4'b0100, 4'b1100, 1);
      step(1, 4'b1100, 0, 0, 0, 4'b0000, 4'b0000, 0);
      step(0, 4'b1100, 0, 0, 0, 4'b0000, 4'b1100, 0);
      step(0, 4'b1100, 0, 0, 0, 4'b1100, 4'b0000, 0);
      step(0, 4'b1100, 0, 0, 0, 4'b0000, 4'b1100, 0);
      step(0, 4'b1100, 0, 0, 0, 4'b1100, 4'b0000, 0);
      // run past the 4-bit counter wrap
      for (int k = 0; k < 14; k++) step(0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0);

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
